// File: rtl/aes_pkg.sv
// aes_pkg: scheduler state encoding and core key-mode constants
package aes_pkg;
  typedef enum logic [2:0] {KEY_IDLE, RUN, DRAIN, SWITCH, KEYWAIT} state_t;
  localparam logic [1:0] KEY128 = 2'd0, KEY192 = 2'd1, KEY256 = 2'd2;
endpackage

// File: rtl/aes_tag_fifo.sv
// aes_tag_fifo: in-order requester-id FIFO (push/pop, full/empty, count = blocks in flight)
module aes_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign rdata = mem[rp];
  always_ff @(posedge clk) if (do_push) mem[wp] <= wdata;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/aes_req_sched.sv
// aes_req_sched: round-robin sharing of one aes core among NUM_REQ requesters (req_*), key control (cfg_*), core drive (aes_*), in-order responses (rsp_*)
module aes_req_sched
  import aes_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TAG_DEPTH = 4,
  parameter int ISSUE_GAP = 3
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_ende,
  input  logic [NUM_REQ*128-1:0]     req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       cfg_start,
  input  logic [255:0]               cfg_key,
  input  logic [1:0]                 cfg_key_mode,
  output logic                       cfg_busy,
  output logic                       rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [127:0]               rsp_data,
  output logic                       aes_start,
  output logic                       aes_enable,
  output logic                       aes_ende,
  output logic [255:0]               aes_key,
  output logic [1:0]                 aes_key_mode,
  output logic [127:0]               aes_data,
  output logic                       aes_data_valid,
  input  logic                       aes_ready,
  input  logic                       aes_key_ready,
  input  logic [127:0]               aes_odata,
  input  logic                       aes_odata_valid
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TAG_DEPTH) + 1;
  localparam int GW = $clog2(ISSUE_GAP + 1);
  state_t state, state_nx;
  logic [IW-1:0] ptr, win, idx, tag;
  logic [GW-1:0] gap;
  logic [1:0] kw;
  logic [255:0] pend_key;
  logic [1:0] pend_mode;
  logic [CW-1:0] inflight;
  logic any, mismatch, grant, full, empty, pop, key_go;
  always_comb begin
    win = ptr;
    idx = ptr;
    any = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = IW'((int'(ptr) + i) % NUM_REQ);
      if (req_valid[idx]) begin
        win = idx;
        any = 1'b1;
      end
    end
  end
  assign mismatch = any && (req_ende[win] != aes_ende);
  assign grant = state == RUN && !cfg_start && any && !mismatch && aes_ready && aes_key_ready && !full && gap == '0;
  assign req_ready = grant ? NUM_REQ'(1) << win : '0;
  assign pop = aes_odata_valid && !empty;
  assign cfg_busy = state == DRAIN || state == KEYWAIT;
  assign aes_enable = 1'b1;
  assign key_go = state == DRAIN && state_nx == KEYWAIT;
  always_comb begin
    state_nx = state;
    if (cfg_start) state_nx = DRAIN;
    else case (state)
      RUN: if (mismatch) state_nx = SWITCH;
      DRAIN: if (inflight == '0) state_nx = KEYWAIT;
      SWITCH: if (inflight == '0) state_nx = RUN;
      KEYWAIT: if (kw == '0 && aes_key_ready) state_nx = RUN;
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= KEY_IDLE;
      ptr <= '0;
      gap <= '0;
      kw <= '0;
      pend_key <= '0;
      pend_mode <= KEY128;
      aes_start <= 1'b0;
      aes_ende <= 1'b0;
      aes_key <= '0;
      aes_key_mode <= KEY128;
      aes_data <= '0;
      aes_data_valid <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_data <= '0;
    end else begin
      state <= state_nx;
      aes_start <= key_go;
      aes_data_valid <= grant;
      rsp_valid <= pop;
      // the core's key_ready is stale during the start cycle and the one after it
      kw <= key_go ? 2'd2 : (kw != '0 ? kw - 2'd1 : kw);
      gap <= grant ? GW'(ISSUE_GAP - 1) : (gap != '0 ? gap - 1'b1 : gap);
      if (cfg_start) begin
        pend_key <= cfg_key;
        pend_mode <= cfg_key_mode;
      end
      if (key_go) begin
        aes_key <= pend_key;
        aes_key_mode <= pend_mode;
      end
      if (state == SWITCH && state_nx == RUN && any) aes_ende <= req_ende[win];
      if (grant) begin
        ptr <= win;
        aes_data <= req_data[int'(win)*128 +: 128];
      end
      if (pop) begin
        rsp_id <= tag;
        rsp_data <= aes_odata;
      end
    end
  aes_tag_fifo #(.DEPTH(TAG_DEPTH), .W(IW)) u_tags (
    .clk(clk), .reset_n(reset_n), .push(grant), .wdata(win), .pop(pop),
    .rdata(tag), .full(full), .empty(empty), .count(inflight)
  );
  assert property (@(posedge clk) disable iff (!reset_n) !(aes_odata_valid && empty));
endmodule

// File: tb/tb_aes_req_sched.sv
// tb_aes_req_sched: directed bench with a behavioural aes core and per-requester queues
module tb_aes_req_sched;
  localparam int N = 4;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] EM = {4{32'ha5a50f0f}};
  localparam logic [127:0] DM = {4{32'h3c3cf0f0}};
  logic clk = 0, reset_n = 0;
  logic [N-1:0] req_valid = '0, req_ende = '0, req_ready;
  logic [N*128-1:0] req_data = '0;
  logic cfg_start = 0, cfg_busy;
  logic [255:0] cfg_key = '0, aes_key;
  logic [1:0] cfg_key_mode = '0, aes_key_mode, rsp_id;
  logic rsp_valid, aes_start, aes_enable, aes_ende, aes_data_valid;
  logic [127:0] rsp_data, aes_data, aes_odata = '0;
  logic aes_ready = 1, aes_key_ready = 0, aes_odata_valid = 0;
  aes_req_sched #(.NUM_REQ(N), .TAG_DEPTH(4), .ISSUE_GAP(3)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ende(req_ende), .req_data(req_data),
    .req_ready(req_ready), .cfg_start(cfg_start), .cfg_key(cfg_key), .cfg_key_mode(cfg_key_mode),
    .cfg_busy(cfg_busy), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .aes_start(aes_start), .aes_enable(aes_enable), .aes_ende(aes_ende), .aes_key(aes_key),
    .aes_key_mode(aes_key_mode), .aes_data(aes_data), .aes_data_valid(aes_data_valid),
    .aes_ready(aes_ready), .aes_key_ready(aes_key_ready), .aes_odata(aes_odata),
    .aes_odata_valid(aes_odata_valid)
  );
  always #5 clk = ~clk;
  typedef struct {int due; logic [127:0] d;} core_t;
  core_t cq[$];
  core_t c;
  logic [127:0] rq_d [N][$];
  logic rq_e [N][$];
  int g_id[$], g_cyc[$], r_id[$], r_cyc[$], i_cyc[$];
  logic [127:0] r_data[$];
  int cyc = 0, kr_cnt = 0, kr_cyc = 0, starts = 0, n_cmp = 0, n_bad = 0;
  bit hold = 0;
  function automatic logic [127:0] core_f(logic [127:0] d, logic e);
    if (!e && d == PT) return CT;
    if (e && d == CT) return PT;
    return d ^ (e ? DM : EM);
  endfunction
  function automatic logic [127:0] dat(int r, int k);
    return {32'hc0de0000 + 32'(r), 32'(k), 64'h0123456789abcdef};
  endfunction
  always @(negedge clk) begin
    cyc++;
    for (int r = 0; r < N; r++)
      if (req_valid[r] && req_ready[r]) begin
        g_id.push_back(r);
        g_cyc.push_back(cyc);
        void'(rq_d[r].pop_front());
        void'(rq_e[r].pop_front());
      end
    if (rsp_valid) begin
      r_id.push_back(int'(rsp_id));
      r_data.push_back(rsp_data);
      r_cyc.push_back(cyc);
    end
    if (aes_data_valid) i_cyc.push_back(cyc);
    if (aes_start) starts++;
    if (!reset_n) begin
      cq.delete();
      aes_odata_valid = 0;
      aes_key_ready = 0;
      kr_cnt = 0;
    end else begin
      if (aes_data_valid) cq.push_back('{cyc + 6, core_f(aes_data, aes_ende)});
      aes_odata_valid = 0;
      if (!hold && cq.size() > 0 && cq[0].due <= cyc) begin
        c = cq.pop_front();
        aes_odata_valid = 1;
        aes_odata = c.d;
      end
      if (aes_start) begin
        aes_key_ready = 0;
        kr_cnt = 6;
      end else if (kr_cnt > 0) begin
        kr_cnt--;
        if (kr_cnt == 0) begin
          aes_key_ready = 1;
          kr_cyc = cyc;
        end
      end
    end
  end
  always @(posedge clk) begin
    #1;
    for (int r = 0; r < N; r++) begin
      req_valid[r] = rq_d[r].size() > 0;
      req_ende[r] = req_valid[r] ? rq_e[r][0] : 1'b0;
      req_data[r*128 +: 128] = req_valid[r] ? rq_d[r][0] : '0;
    end
  end
  task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push(int r, logic [127:0] d, logic e);
    rq_d[r].push_back(d);
    rq_e[r].push_back(e);
  endtask
  task automatic clear();
    g_id.delete(); g_cyc.delete(); r_id.delete(); r_cyc.delete(); r_data.delete(); i_cyc.delete();
    starts = 0;
  endtask
  task automatic wait_rsp(int n, string tag);
    int k = 0;
    while (r_id.size() < n && k < 400) begin
      tick(1);
      k++;
    end
    chk(tag, r_id.size(), n);
  endtask
  task automatic wait_run(string tag);
    int k = 0;
    while (cfg_busy && k < 200) begin
      tick(1);
      k++;
    end
    chk(tag, cfg_busy, 0);
  endtask
  task automatic load_key(logic [255:0] k, logic [1:0] m);
    cfg_key = k;
    cfg_key_mode = m;
    cfg_start = 1;
    tick(1);
    cfg_start = 0;
  endtask
  task automatic chk_reset(string tag);
    chk({tag, "_ctrl"}, {req_ready, cfg_busy, rsp_valid, aes_start, aes_enable, aes_ende, aes_data_valid, rsp_id, aes_key_mode}, 14'b0000_0001_0000_00);
    chk({tag, "_key"}, aes_key, '0);
    chk({tag, "_data"}, {aes_data, rsp_data}, '0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tick(3);
    chk_reset("rst");
    reset_n = 1;
    push(0, PT, 0);
    tick(8);
    chk("idle_nogrant", g_id.size(), 0);
    rq_d[0].delete();
    rq_e[0].delete();
    tick(2);
    clear();
    // 1: key load, single encrypt on requester 2
    load_key({K128, 128'h0}, 2'd0);
    chk("t1_busy", cfg_busy, 1);
    wait_run("t1_run");
    chk("t1_key", aes_key, {K128, 128'h0});
    chk("t1_mode", aes_key_mode, 2'd0);
    chk("t1_starts", starts, 1);
    chk("t1_nogrant_busy", g_id.size(), 0);
    push(2, PT, 0);
    wait_rsp(1, "t1_rsp_to");
    chk("t1_id", r_id[0], 2);
    chk("t1_data", r_data[0], CT);
    push(3, dat(3, 9), 0);
    wait_rsp(2, "t1b_rsp_to");
    chk("t1b_id", r_id[1], 3);
    clear();
    // 2: all four requesters, round robin and issue spacing
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < N; r++) push(r, dat(r, k), 0);
    wait_rsp(8, "t2_rsp_to");
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_gid%0d", i), g_id[i], i % 4);
      chk($sformatf("t2_rid%0d", i), r_id[i], i % 4);
      chk($sformatf("t2_rdata%0d", i), r_data[i], dat(i % 4, i / 4) ^ EM);
    end
    for (int i = 1; i < 8; i++) chk($sformatf("t2_gap%0d", i), i_cyc[i] - i_cyc[i-1], 3);
    clear();
    // 3: direction switch drains the core first
    push(0, PT, 0);
    push(1, CT, 1);
    wait_rsp(2, "t3_rsp_to");
    chk("t3_g0", g_id[0], 0);
    chk("t3_g1", g_id[1], 1);
    chk("t3_switch_wait", g_cyc[1] > r_cyc[0], 1);
    chk("t3_r0", {r_id[0][1:0], r_data[0]}, {2'd0, CT});
    chk("t3_r1", {r_id[1][1:0], r_data[1]}, {2'd1, PT});
    chk("t3_ende", aes_ende, 1);
    clear();
    // 4: key change with three blocks in flight
    hold = 1;
    for (int r = 0; r < 3; r++) push(r, dat(r, 4), 1);
    for (int k = 0; k < 100 && i_cyc.size() < 3; k++) tick(1);
    chk("t4_issued", i_cyc.size(), 3);
    load_key(K256, 2'd2);
    push(3, dat(3, 4), 1);
    tick(10);
    chk("t4_nogrant", g_id.size(), 3);
    chk("t4_busy", cfg_busy, 1);
    chk("t4_nostart", starts, 0);
    hold = 0;
    wait_rsp(4, "t4_rsp_to");
    chk("t4_starts", starts, 1);
    chk("t4_key", {aes_key_mode, aes_key}, {2'd2, K256});
    chk("t4_g3", g_id[3], 3);
    chk("t4_after_rsp", g_cyc[3] > r_cyc[2], 1);
    chk("t4_after_kr", g_cyc[3] > kr_cyc, 1);
    chk("t4_r3", r_data[3], dat(3, 4) ^ DM);
    clear();
    // 5: core stalls, tag FIFO fills
    hold = 1;
    for (int k = 0; k < 6; k++) push(0, dat(0, 10 + k), 1);
    tick(40);
    chk("t5_full_stop", g_id.size(), 4);
    hold = 0;
    wait_rsp(6, "t5_rsp_to");
    chk("t5_resume", g_cyc[4], r_cyc[0]);
    chk("t5_r5", r_data[5], dat(0, 15) ^ DM);
    clear();
    // 6: async reset during KEYWAIT
    load_key({K128, 128'h0}, 2'd0);
    for (int k = 0; k < 50 && starts == 0; k++) tick(1);
    chk("t6_start", starts, 1);
    tick(1);
    reset_n = 0;
    #1;
    chk_reset("t6_rst");
    tick(2);
    reset_n = 1;
    aes_key_ready = 1;
    clear();
    push(1, PT, 0);
    tick(10);
    chk("t6_idle", {g_id.size() == 0, cfg_busy}, 2'b10);
    load_key({K128, 128'h0}, 2'd0);
    wait_rsp(1, "t6_rsp_to");
    chk("t6_r", {r_id[0][1:0], r_data[0]}, {2'd1, CT});
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
